mem_initiator: RTL and testbench

Bus-master front end for the memory block's valid/ready interface. Accepts single read or write requests from a user-side request/response port and drives the memory's valid, wr_rd, addr and wdata until the memory returns ready. Returns read data and completion status on the response port. Sits between the test or system logic and the memory, as the initiator end of the same interface the memory checker monitors.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_init_timer.sv | 43 ++++
 rtl/mem_initiator.sv | 153 +++++++++++++++
 tb/tb_mem_initiator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared types and default sizes for the memory block, its       |
// |           checker and the mem_initiator bus master.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_pkg;

   localparam int MEM_WIDTH = 16;
   localparam int MEM_DEPTH = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } mem_init_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_init_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_init_timer : counts ISSUE cycles without ready and flags the cycle   |
// |                  on whose closing edge the TIMEOUT-th miss would land.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_init_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != CNT_W'(TIMEOUT))) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry fires on the edge that would take the count to TIMEOUT, so valid
   // is held for exactly TIMEOUT cycles before giving up.
   assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_initiator : single-outstanding valid/ready bus master front end.     |
// | Optional ISSUE timeout enabled by defining MEM_INIT_TIMEOUT_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_initiator
   import mem_pkg::*;
#(
   parameter int WIDTH      = MEM_WIDTH,
   parameter int DEPTH      = MEM_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_wr,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_err,
   output logic                  valid,
   output logic                  wr_rd,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [WIDTH-1:0]      wdata,
   input  logic                  ready,
   input  logic [WIDTH-1:0]      rdata,
   output logic                  busy
);

   mem_init_state_e       state_q, state_d;
   logic                  req_ready_q, req_ready_d;
   logic                  valid_q, valid_d;
   logic                  wr_rd_q, wr_rd_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_wr_q, rsp_wr_d;
   logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  timeout_expired;

`ifdef MEM_INIT_TIMEOUT_EN
   mem_init_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_q != ISSUE),
      .enable_i  ((state_q == ISSUE) && !ready),
      .expired_o (timeout_expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout  = (TIMEOUT > 0);
   assign timeout_expired = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      wr_rd_d     = wr_rd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_wr_d    = rsp_wr_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               wr_rd_d = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // ready on the expiry edge still counts as a normal completion
            if (ready) begin
               valid_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_wr_d    = wr_rd_q;
               rsp_rdata_d = wr_rd_q ? '0 : rdata;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else if (timeout_expired) begin
               valid_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_wr_d    = wr_rd_q;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         valid_q     <= 1'b0;
         wr_rd_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_wr_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         valid_q     <= valid_d;
         wr_rd_q     <= wr_rd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign valid     = valid_q;
   assign wr_rd     = wr_rd_q;
   assign addr      = addr_q;
   assign wdata     = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_wr    = rsp_wr_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_initiator : vector table, corner sequences and random traffic     |
// |                    against a word-array reference of the memory.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_initiator;

   localparam int WIDTH   = 16;
   localparam int DEPTH   = 64;
   localparam int AW      = 6;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_wr;
   logic [AW-1:0] req_addr;
   logic [15:0]   req_wdata;
   logic          rsp_valid, rsp_ready, rsp_wr, rsp_err;
   logic [15:0]   rsp_rdata;
   logic          valid, wr_rd, ready, busy;
   logic [AW-1:0] addr;
   logic [15:0]   wdata, rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] bus_mem [DEPTH];
   logic [15:0] ref_mem [DEPTH];

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [15:0] wdata;
      int          dly;
      int          hold;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   mem_initiator #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_wr    (rsp_wr),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .valid     (valid),
      .wr_rd     (wr_rd),
      .addr      (addr),
      .wdata     (wdata),
      .ready     (ready),
      .rdata     (rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One request from IDLE: ready arrives dly cycles after valid rises,
   // response held for hold cycles before rsp_ready. exp_err selects the
   // timeout path (memory never answers).
   task automatic do_txn(input logic wr, input logic [5:0] a, input logic [15:0] d,
                         input int dly, input int hold, input logic [15:0] exp_rd,
                         input logic exp_err);
      int last;
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      step();
      req_valid = 1'b0;
      req_wr    = 1'($urandom);
      req_addr  = 6'($urandom);
      req_wdata = 16'($urandom);
      last = exp_err ? TIMEOUT : dly + 1;
      for (int k = 1; k <= last; k++) begin
         chk("valid_issue", valid, 1);
         chk("wr_rd_issue", wr_rd, wr);
         chk("addr_issue", addr, a);
         chk("wdata_issue", wdata, d);
         chk("busy_issue", busy, 1);
         chk("req_ready_issue", req_ready, 0);
         chk("rsp_valid_issue", rsp_valid, 0);
         if (!exp_err && k == last) begin
            ready = 1'b1;
            if (wr_rd) begin
               bus_mem[addr] = wdata;
               rdata = 16'($urandom);
            end else begin
               rdata = bus_mem[addr];
            end
         end else begin
            ready = 1'b0;
            rdata = 16'($urandom);
         end
         step();
      end
      ready = 1'b0;
      rdata = 16'($urandom);
      for (int h = 0; h <= hold; h++) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_wr", rsp_wr, wr);
         chk("rsp_rdata", rsp_rdata, exp_rd);
         chk("rsp_err", rsp_err, exp_err);
         chk("valid_resp", valid, 0);
         chk("req_ready_resp", req_ready, 0);
         if (h == hold) begin
            rsp_ready = 1'b1;
            req_valid = 1'b0;
         end else begin
            rsp_ready = 1'b0;
            req_valid = (h > 0);
         end
         step();
      end
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("rsp_valid_done", rsp_valid, 0);
      chk("busy_done", busy, 0);
      chk("valid_done", valid, 0);
      chk("req_ready_done", req_ready, 1);
   endtask

   initial begin
      logic        w;
      logic [5:0]  a;
      logic [15:0] d;
      logic [15:0] e;

      for (int i = 0; i < DEPTH; i++) begin
         bus_mem[i] = '0;
         ref_mem[i] = '0;
      end
      vecs[0] = '{1'b1, 6'd5,  16'hA5A5, 1, 0, 16'h0000};
      vecs[1] = '{1'b0, 6'd5,  16'h0000, 1, 0, 16'hA5A5};
      vecs[2] = '{1'b1, 6'd63, 16'hFFFF, 4, 0, 16'h0000};
      vecs[3] = '{1'b0, 6'd63, 16'h0000, 4, 0, 16'hFFFF};
      vecs[4] = '{1'b1, 6'd0,  16'h0F0F, 0, 5, 16'h0000};
      vecs[5] = '{1'b0, 6'd0,  16'h0000, 1, 5, 16'h0F0F};
      vecs[6] = '{1'b0, 6'd1,  16'h0000, 2, 1, 16'h0000};
      vecs[7] = '{1'b0, 6'd5,  16'h0000, 0, 0, 16'hA5A5};

      rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; ready = 1'b0; rdata = '0;

      for (int c = 0; c < 3; c++) begin
         step();
         chk("reset_outputs", {req_ready, rsp_valid, rsp_wr, rsp_err, valid, wr_rd, busy,
                               addr, wdata, rsp_rdata}, 0);
      end
      rst = 1'b1;
      #1;
      chk("req_ready_before_edge", req_ready, 0);
      step();
      chk("req_ready_after_release", req_ready, 1);
      chk("valid_after_release", valid, 0);

      for (int i = 0; i < 8; i++) begin
         do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].hold,
                vecs[i].exp_rdata, 1'b0);
         if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
      end

      // reset while a write is waiting for ready: it must vanish entirely
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 6'd10; req_wdata = 16'hDEAD;
      step();
      req_valid = 1'b0;
      chk("mid_valid_1", valid, 1);
      step();
      chk("mid_valid_2", valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 0);
      step();
      step();
      chk("mid_rst_rsp_hold", rsp_valid, 0);
      rst = 1'b1;
      step();
      chk("mid_rel_req_ready", req_ready, 1);
      chk("mid_rel_rsp", rsp_valid, 0);
      do_txn(1'b0, 6'd10, 16'h0, 1, 0, ref_mem[10], 1'b0);

`ifdef MEM_INIT_TIMEOUT_EN
      do_txn(1'b0, 6'd7, 16'h0, 100, 0, 16'h0, 1'b1);
      do_txn(1'b1, 6'd9, 16'hBEEF, 100, 0, 16'h0, 1'b1);
      do_txn(1'b0, 6'd9, 16'h0, 1, 0, ref_mem[9], 1'b0);
      do_txn(1'b0, 6'd5, 16'h0, TIMEOUT - 1, 0, ref_mem[5], 1'b0);
`else
      do_txn(1'b0, 6'd5, 16'h0, 20, 0, ref_mem[5], 1'b0);
`endif

      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom);
         a = 6'($urandom);
         d = 16'($urandom);
         e = w ? 16'h0000 : ref_mem[a];
         do_txn(w, a, d, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), e, 1'b0);
         if (w) ref_mem[a] = d;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
